// File: rtl/rps_pkg.sv
// Shared encodings for the stone-paper-scissors match logic: moves, round results, FSM states.
package rps_pkg;

    localparam logic [1:0] MV_STONE    = 2'b00;
    localparam logic [1:0] MV_PAPER    = 2'b01;
    localparam logic [1:0] MV_SCISSORS = 2'b10;
    localparam logic [1:0] MV_INVALID  = 2'b11;

    localparam logic [1:0] RES_TIE     = 2'b00;
    localparam logic [1:0] RES_P1      = 2'b01;
    localparam logic [1:0] RES_P2      = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_JUDGE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Each legal move beats the one just below it in the cycle stone -> paper -> scissors -> stone.
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return a == ((b == MV_SCISSORS) ? MV_STONE : b + 2'd1);
    endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational referee for one round; an invalid move from either side outranks a tie.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    output logic [1:0] result
);

    always_comb begin
        result = RES_TIE;
        if (p1_move == MV_INVALID || p2_move == MV_INVALID) begin
            result = RES_INVALID;
        end else if (p1_move == p2_move) begin
            result = RES_TIE;
        end else if (beats(p1_move, p2_move)) begin
            result = RES_P1;
        end else begin
            result = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_controller.sv
// Best-of-N match sequencer: collects one move per player, judges the round, keeps score.
// Optional opponent timeout is built when RPS_TIMEOUT_EN is defined.
module rps_match_controller
    import rps_pkg::*;
#(
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    output logic       round_valid,
    output logic [1:0] round_result,
    output logic       round_timeout,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] WIN = 4'(ROUNDS_TO_WIN);

    logic [1:0] state;
    logic       p1_locked, p2_locked;
    logic [1:0] p1_mv, p2_mv;
    logic [3:0] p1_sc, p2_sc;
    logic [3:0] p1_next, p2_next;
    logic [1:0] judge_res, res_eff;
    logic       p1_hs, p2_hs, both_next;
    logic       to_fire, timed_out;

    // A move transfers on an edge where valid and ready are both high; ready never depends on valid.
    assign p1_ready  = (state == ST_COLLECT) && !p1_locked;
    assign p2_ready  = (state == ST_COLLECT) && !p2_locked;
    assign p1_hs     = p1_valid && p1_ready;
    assign p2_hs     = p2_valid && p2_ready;
    assign both_next = (p1_locked || p1_hs) && (p2_locked || p2_hs);

    rps_round_judge u_judge (
        .p1_move (p1_mv),
        .p2_move (p2_mv),
        .result  (judge_res)
    );

`ifdef RPS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    assign to_fire = (state == ST_COLLECT) && (p1_locked ^ p2_locked) && !both_next
                     && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || abort || state != ST_COLLECT) begin
            to_cnt <= '0;
        end else if (p1_locked ^ p2_locked) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            timed_out <= 1'b0;
        end else if (state == ST_COLLECT) begin
            timed_out <= to_fire;
        end
    end

    // On timeout only the locked side's move is meaningful.
    always_comb begin
        res_eff = judge_res;
        if (timed_out) begin
            if (p1_locked) res_eff = (p1_mv == MV_INVALID) ? RES_INVALID : RES_P1;
            else           res_eff = (p2_mv == MV_INVALID) ? RES_INVALID : RES_P2;
        end
    end
`else
    // TIMEOUT_CYCLES stays in the parameter list so both builds share one interface.
    assign to_fire   = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign timed_out = 1'b0;
    assign res_eff   = judge_res;
`endif

    assign p1_next = (p1_sc < WIN) ? p1_sc + 4'd1 : p1_sc;
    assign p2_next = (p2_sc < WIN) ? p2_sc + 4'd1 : p2_sc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            p1_locked     <= 1'b0;
            p2_locked     <= 1'b0;
            p1_mv         <= MV_STONE;
            p2_mv         <= MV_STONE;
            p1_sc         <= 4'd0;
            p2_sc         <= 4'd0;
            round_valid   <= 1'b0;
            round_result  <= RES_TIE;
            round_timeout <= 1'b0;
        end else begin
            round_valid   <= 1'b0;
            round_timeout <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                p1_locked <= 1'b0;
                p2_locked <= 1'b0;
                p1_sc     <= 4'd0;
                p2_sc     <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state     <= ST_COLLECT;
                            p1_locked <= 1'b0;
                            p2_locked <= 1'b0;
                            p1_sc     <= 4'd0;
                            p2_sc     <= 4'd0;
                        end
                    end
                    ST_COLLECT: begin
                        if (p1_hs) begin
                            p1_locked <= 1'b1;
                            p1_mv     <= p1_move;
                        end
                        if (p2_hs) begin
                            p2_locked <= 1'b1;
                            p2_mv     <= p2_move;
                        end
                        if (both_next || to_fire) state <= ST_JUDGE;
                    end
                    ST_JUDGE: begin
                        round_result  <= res_eff;
                        round_valid   <= 1'b1;
                        round_timeout <= timed_out;
                        p1_locked     <= 1'b0;
                        p2_locked     <= 1'b0;
                        state         <= ST_COLLECT;
                        if (res_eff == RES_P1) begin
                            p1_sc <= p1_next;
                            if (p1_next == WIN) state <= ST_DONE;
                        end else if (res_eff == RES_P2) begin
                            p2_sc <= p2_next;
                            if (p2_next == WIN) state <= ST_DONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign p1_score     = p1_sc;
    assign p2_score     = p2_sc;
    assign match_done   = (state == ST_DONE);
    assign match_winner = !match_done ? 2'b00 : ((p1_sc == WIN) ? RES_P1 : RES_P2);
    assign busy         = (state == ST_COLLECT) || (state == ST_JUDGE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed and randomized bench for rps_match_controller; define RPS_TIMEOUT_EN to cover the timeout build.
module tb_rps_match_controller;
    import rps_pkg::*;

    localparam int R = 2;
`ifdef RPS_TIMEOUT_EN
    localparam int TO       = 4;
    localparam int MAX_SKEW = 2;
    localparam int STAG     = 2;
`else
    localparam int TO       = 255;
    localparam int MAX_SKEW = 6;
    localparam int STAG     = 5;
`endif

    logic       clk, rst, start, abort;
    logic       p1_valid, p2_valid, p1_ready, p2_ready;
    logic [1:0] p1_move, p2_move;
    logic       round_valid, round_timeout, match_done, busy;
    logic [1:0] round_result, match_winner, state_dbg;
    logic [3:0] p1_score, p2_score;

    int total = 0;
    int bad   = 0;
    int s1    = 0;
    int s2    = 0;
    logic [10:0] exp_q[$];

    rps_match_controller #(.ROUNDS_TO_WIN(R), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .round_valid(round_valid), .round_result(round_result), .round_timeout(round_timeout),
        .p1_score(p1_score), .p2_score(p2_score), .match_done(match_done),
        .match_winner(match_winner), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: rock-paper-scissors as (p1 - p2) mod 3 -> 0 tie, 1 P1, 2 P2.
    task automatic model_round(input logic [1:0] m1, input logic [1:0] m2,
                               input bit to, input bit p1_is_locked);
        int r;
        int a;
        int b;
        a = int'(m1);
        b = int'(m2);
        if (to) begin
            if (p1_is_locked) r = (a == 3) ? 3 : 1;
            else              r = (b == 3) ? 3 : 2;
        end else if (a == 3 || b == 3) begin
            r = 3;
        end else begin
            r = (a - b + 3) % 3;
        end
        if (r == 1 && s1 < R) s1++;
        if (r == 2 && s2 < R) s2++;
        exp_q.push_back({to, r[1:0], s1[3:0], s2[3:0]});
    endtask

    // scoreboard: every round_valid pulse must match the oldest expected round
    always @(negedge clk) begin
        if (round_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_round observed=%0h expected=none",
                       {round_timeout, round_result, p1_score, p2_score});
            end else begin
                check("round", {21'd0, round_timeout, round_result, p1_score, p2_score},
                      {21'd0, exp_q.pop_front()});
            end
        end
    end

    // drivers: every task starts and ends just after a falling edge
    task automatic start_match();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s1 = 0;
        s2 = 0;
        check("start_state", state_dbg, ST_COLLECT);
        check("start_busy", busy, 1);
        check("start_scores", {p1_score, p2_score}, 0);
    endtask

    task automatic play(input logic [1:0] m1, input logic [1:0] m2, input int skew);
        check("p1_ready", p1_ready, 1);
        check("p2_ready", p2_ready, 1);
        model_round(m1, m2, 1'b0, 1'b0);
        p1_valid = 1'b1;
        p1_move  = m1;
        if (skew > 0) begin
            @(negedge clk);
            for (int i = 1; i < skew; i++) begin
                check("locked_ready", p1_ready, 0);
                p1_move = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            check("locked_ready", p1_ready, 0);
            p1_move = ~m1;
        end
        p2_valid = 1'b1;
        p2_move  = m2;
        @(negedge clk);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        check("judge_state", state_dbg, ST_JUDGE);
        @(negedge clk);
        check("round_latency", round_valid, 1);
        check("match_done", match_done, (s1 == R || s2 == R));
        check("match_winner", match_winner, (s1 == R) ? 1 : ((s2 == R) ? 2 : 0));
    endtask

    initial begin
        int guard;
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_round_valid", round_valid, 0);
        check("rst_round_result", round_result, 0);
        check("rst_round_timeout", round_timeout, 0);
        check("rst_scores", {p1_score, p2_score}, 0);
        check("rst_done", {match_done, match_winner, busy}, 0);
        check("rst_ready", {p1_ready, p2_ready}, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", state_dbg, ST_IDLE);

        // 1: straight win 2-0
        start_match();
        play(MV_PAPER, MV_STONE, 0);
        play(MV_SCISSORS, MV_PAPER, 0);
        check("t1_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t1_hold_scores", {p1_score, p2_score}, {4'd2, 4'd0});
        check("t1_hold_result", round_result, RES_P1);

        // 2: tie, invalid, then random rounds to a winner
        start_match();
        play(MV_STONE, MV_STONE, 0);
        check("t2_replay", state_dbg, ST_COLLECT);
        play(MV_INVALID, MV_PAPER, 0);
        guard = 0;
        while (!(s1 == R || s2 == R) && guard < 200) begin
            play(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, MAX_SKEW));
            guard++;
        end
        check("t2_done", match_done, 1);

        // 3: P1 locks then keeps offering; P2 arrives later
        start_match();
        play(MV_STONE, MV_SCISSORS, STAG);
        check("t3_state", state_dbg, ST_COLLECT);

        // 4: abort while in JUDGE, then abort+start from DONE
        p1_valid = 1'b1; p1_move = MV_PAPER;
        p2_valid = 1'b1; p2_move = MV_STONE;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        check("t4_judge", state_dbg, ST_JUDGE);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_state", state_dbg, ST_IDLE);
        check("t4_abort_valid", round_valid, 0);
        check("t4_abort_scores", {p1_score, p2_score}, 0);
        start_match();
        play(MV_PAPER, MV_STONE, 0);
        play(MV_PAPER, MV_STONE, 0);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("t4_abort_start", state_dbg, ST_IDLE);
        check("t4_abort_done", {match_done, match_winner}, 0);

        // 5: only P2 locks
        start_match();
        p2_valid = 1'b1; p2_move = MV_SCISSORS;
`ifdef RPS_TIMEOUT_EN
        model_round(MV_STONE, MV_SCISSORS, 1'b1, 1'b0);
        @(negedge clk);
        p2_valid = 1'b0;
        n = 0;
        while (round_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout_seen", round_valid, 1);
        check("t5_timeout_min", (n >= TO), 1);
        check("t5_timeout_max", (n <= TO + 2), 1);
        @(negedge clk);
`else
        @(negedge clk);
        p2_valid = 1'b0;
        n = 0;
        repeat (1000) @(negedge clk);
        check("t5_wait_state", state_dbg, ST_COLLECT);
        check("t5_wait_ready", {p1_ready, p2_ready}, 2'b10);
        check("t5_wait_timeout", round_timeout, 0);
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // 6: reset in COLLECT with P1 locked
        start_match();
        p1_valid = 1'b1; p1_move = MV_PAPER;
        @(negedge clk);
        p1_valid = 1'b0;
        check("t6_locked", p1_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_state", state_dbg, ST_IDLE);
        check("t6_outputs", {round_valid, round_result, round_timeout, p1_score, p2_score,
                             match_done, match_winner, busy, p1_ready, p2_ready}, 0);
        start_match();
        check("t6_lock_cleared", p1_ready, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
